// File: rtl/rename_group_n.sv
// rename_group_n: N-wide register-rename stage between decode and dispatch.
// Reads RAT mappings, allocates free physical registers, resolves in-group
// RAW/WAW hazards, reserves ROB entries and registers the renamed group into
// a one-entry output stage. Groups are accepted all-or-nothing.
// Optional stall/throughput counters: define RENAME_GROUP_STATS_EN.
module rename_group_n #(
  parameter int WIDTH     = 4,
  parameter int ARCH_REGS = 32,
  parameter int PHY_REGS  = 64,
  parameter int PHY_WIDTH = 6,
  parameter int ROB_WIDTH = 5,
  parameter int PAYLOAD_W = 64,
  localparam int AW       = $clog2(ARCH_REGS),
  localparam int FLW      = $clog2(PHY_REGS) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [WIDTH-1:0]               in_valid,
  output logic                           in_ready,
  input  logic [WIDTH*AW-1:0]            in_rs1_arch,
  input  logic [WIDTH*AW-1:0]            in_rs2_arch,
  input  logic [WIDTH*AW-1:0]            in_rd_arch,
  input  logic [WIDTH-1:0]               in_wr_rd,
  input  logic [WIDTH*PAYLOAD_W-1:0]     in_payload,
  input  logic [WIDTH*PHY_WIDTH-1:0]     rat_rs1_phy,
  input  logic [WIDTH*PHY_WIDTH-1:0]     rat_rs2_phy,
  input  logic [WIDTH*PHY_WIDTH-1:0]     rat_rd_phy,
  output logic [WIDTH-1:0]               rat_wr_en,
  input  logic [FLW-1:0]                 fl_avail,
  input  logic [WIDTH*PHY_WIDTH-1:0]     fl_phy,
  output logic [WIDTH-1:0]               fl_pop,
  input  logic [ROB_WIDTH:0]             rob_free,
  input  logic [ROB_WIDTH-1:0]           rob_tail,
  output logic [WIDTH-1:0]               rob_alloc,
  output logic [WIDTH-1:0]               busy_set,
  output logic [WIDTH*PHY_WIDTH-1:0]     new_phy,
  output logic [WIDTH*PHY_WIDTH-1:0]     old_phy,
  output logic [WIDTH-1:0]               out_valid,
  input  logic                           out_ready,
  output logic [WIDTH*PHY_WIDTH-1:0]     out_rs1_phy,
  output logic [WIDTH*PHY_WIDTH-1:0]     out_rs2_phy,
  output logic [WIDTH*PHY_WIDTH-1:0]     out_rd_phy,
  output logic [WIDTH*ROB_WIDTH-1:0]     out_rob_id,
  output logic [WIDTH*PAYLOAD_W-1:0]     out_payload
`ifdef RENAME_GROUP_STATS_EN
  ,
  output logic [31:0]                    stat_fl_stall,
  output logic [31:0]                    stat_rob_stall,
  output logic [31:0]                    stat_bp_stall,
  output logic [31:0]                    stat_groups
`endif
);

  logic [WIDTH-1:0][AW-1:0]        rs1_a, rs2_a, rd_a;
  logic [WIDTH-1:0][PHY_WIDTH-1:0] rat_rs1, rat_rs2, rat_rd, fl_p;
  logic [WIDTH-1:0][PHY_WIDTH-1:0] new_p, old_p, ren_rs1, ren_rs2;
  logic [WIDTH-1:0][ROB_WIDTH-1:0] rob_id;
  logic [WIDTH-1:0]                wdest;
  int                              n_dest, n_valid, k;
  logic                            fl_ok, rob_ok, out_free, fire;

  logic [WIDTH-1:0]                out_valid_q, out_valid_d;
  logic [WIDTH*PHY_WIDTH-1:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [WIDTH*ROB_WIDTH-1:0]      rob_q, rob_d;
  logic [WIDTH*PAYLOAD_W-1:0]      pay_q, pay_d;

  assign rs1_a   = in_rs1_arch;
  assign rs2_a   = in_rs2_arch;
  assign rd_a    = in_rd_arch;
  assign rat_rs1 = rat_rs1_phy;
  assign rat_rs2 = rat_rs2_phy;
  assign rat_rd  = rat_rd_phy;
  assign fl_p    = fl_phy;
  assign new_phy = new_p;
  assign old_phy = old_p;

  // Destination qualifiers and group resource demand.
  always_comb begin
    wdest   = '0;
    n_dest  = 0;
    n_valid = 0;
    for (int i = 0; i < WIDTH; i++) begin
      wdest[i] = in_valid[i] && in_wr_rd[i] && (rd_a[i] != '0);
      if (wdest[i])    n_dest  = n_dest + 1;
      if (in_valid[i]) n_valid = n_valid + 1;
    end
  end

  // Allocation by prefix count, then in-group bypass; later j overrides earlier
  // so the youngest older producer wins.
  always_comb begin
    new_p   = '0;
    old_p   = '0;
    ren_rs1 = '0;
    ren_rs2 = '0;
    rob_id  = '0;
    k       = 0;
    for (int i = 0; i < WIDTH; i++) begin
      k = 0;
      for (int j = 0; j < WIDTH; j++)
        if (j < i && wdest[j]) k = k + 1;
      for (int m = 0; m < WIDTH; m++)
        if (wdest[i] && m == k) new_p[i] = fl_p[m];
    end
    for (int i = 0; i < WIDTH; i++) begin
      ren_rs1[i] = (rs1_a[i] == '0) ? '0 : rat_rs1[i];
      ren_rs2[i] = (rs2_a[i] == '0) ? '0 : rat_rs2[i];
      old_p[i]   = rat_rd[i];
      for (int j = 0; j < WIDTH; j++) begin
        if (j < i && wdest[j]) begin
          if (rs1_a[i] != '0 && rd_a[j] == rs1_a[i]) ren_rs1[i] = new_p[j];
          if (rs2_a[i] != '0 && rd_a[j] == rs2_a[i]) ren_rs2[i] = new_p[j];
          if (rd_a[j] == rd_a[i])                    old_p[i]   = new_p[j];
        end
      end
      rob_id[i] = rob_tail + ROB_WIDTH'(i);
    end
  end

  // Group acceptance and side-effect strobes; nothing moves during reset or flush.
  always_comb begin
    fl_ok    = int'(fl_avail) >= n_dest;
    rob_ok   = int'(rob_free) >= n_valid;
    out_free = (out_valid_q == '0) || out_ready;
    in_ready = !rst && !flush && fl_ok && rob_ok && out_free;
    fire     = in_ready && (|in_valid);
    fl_pop   = '0;
    for (int i = 0; i < WIDTH; i++)
      fl_pop[i] = fire && (i < n_dest);
    rat_wr_en = fire ? wdest : '0;
    busy_set  = rat_wr_en;
    rob_alloc = fire ? in_valid : '0;
  end

  // Output stage next state: flush empties, fire loads, drain empties, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rob_d       = rob_q;
    pay_d       = pay_q;
    if (flush) begin
      out_valid_d = '0;
    end else if (fire) begin
      out_valid_d = in_valid;
      rs1_d       = ren_rs1;
      rs2_d       = ren_rs2;
      rd_d        = new_p;
      rob_d       = rob_id;
      pay_d       = in_payload;
    end else if (out_ready) begin
      out_valid_d = '0;
    end
  end

  // Output stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rob_q       <= '0;
      pay_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rob_q       <= rob_d;
      pay_q       <= pay_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_rs1_phy = rs1_q;
  assign out_rs2_phy = rs2_q;
  assign out_rd_phy  = rd_q;
  assign out_rob_id  = rob_q;
  assign out_payload = pay_q;

`ifdef RENAME_GROUP_STATS_EN
  logic [31:0] fl_stall_q, rob_stall_q, bp_stall_q, groups_q;
  logic        stall;

  assign stall = (|in_valid) && !in_ready && !flush;

  // Saturating counters; a stall is charged to the first short resource.
  always_ff @(posedge clk) begin
    if (rst) begin
      fl_stall_q  <= '0;
      rob_stall_q <= '0;
      bp_stall_q  <= '0;
      groups_q    <= '0;
    end else begin
      if (stall) begin
        if (!fl_ok) begin
          if (fl_stall_q != '1) fl_stall_q <= fl_stall_q + 32'd1;
        end else if (!rob_ok) begin
          if (rob_stall_q != '1) rob_stall_q <= rob_stall_q + 32'd1;
        end else begin
          if (bp_stall_q != '1) bp_stall_q <= bp_stall_q + 32'd1;
        end
      end
      if (fire && groups_q != '1) groups_q <= groups_q + 32'd1;
    end
  end

  assign stat_fl_stall  = fl_stall_q;
  assign stat_rob_stall = rob_stall_q;
  assign stat_bp_stall  = bp_stall_q;
  assign stat_groups    = groups_q;
`endif

  // Valid slots must be packed from slot 0.
  a_contig: assert property (@(posedge clk) disable iff (rst)
    ((in_valid + WIDTH'(1)) & in_valid) == '0);

endmodule

// File: tb/tb_rename_group_n.sv
// Directed, table-driven bench for rename_group_n at WIDTH=4.
// RAT model: every architectural register a maps to physical a+4.
module tb_rename_group_n;

  logic         clk = 1'b0;
  logic         rst, flush, in_ready, out_ready;
  logic [3:0]   in_valid, in_wr_rd, rat_wr_en, fl_pop, rob_alloc, busy_set, out_valid;
  logic [19:0]  in_rs1_arch, in_rs2_arch, in_rd_arch;
  logic [255:0] in_payload, out_payload;
  logic [23:0]  rat_rs1_phy, rat_rs2_phy, rat_rd_phy, fl_phy, new_phy, old_phy;
  logic [23:0]  out_rs1_phy, out_rs2_phy, out_rd_phy;
  logic [6:0]   fl_avail;
  logic [5:0]   rob_free;
  logic [4:0]   rob_tail;
  logic [19:0]  out_rob_id;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_rat
    assign rat_rs1_phy[g*6 +: 6] = {1'b0, in_rs1_arch[g*5 +: 5]} + 6'd4;
    assign rat_rs2_phy[g*6 +: 6] = {1'b0, in_rs2_arch[g*5 +: 5]} + 6'd4;
    assign rat_rd_phy[g*6 +: 6]  = {1'b0, in_rd_arch[g*5 +: 5]} + 6'd4;
  end

  rename_group_n dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_arch(in_rs1_arch), .in_rs2_arch(in_rs2_arch), .in_rd_arch(in_rd_arch),
    .in_wr_rd(in_wr_rd), .in_payload(in_payload),
    .rat_rs1_phy(rat_rs1_phy), .rat_rs2_phy(rat_rs2_phy), .rat_rd_phy(rat_rd_phy),
    .rat_wr_en(rat_wr_en), .fl_avail(fl_avail), .fl_phy(fl_phy), .fl_pop(fl_pop),
    .rob_free(rob_free), .rob_tail(rob_tail), .rob_alloc(rob_alloc),
    .busy_set(busy_set), .new_phy(new_phy), .old_phy(old_phy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_phy(out_rs1_phy), .out_rs2_phy(out_rs2_phy), .out_rd_phy(out_rd_phy),
    .out_rob_id(out_rob_id), .out_payload(out_payload)
  );

  typedef struct {
    logic [3:0]  valid, wr;
    logic [19:0] rs1, rs2, rd;
    logic [6:0]  fl_avail;
    logic [23:0] fl_phy;
    logic [5:0]  rob_free;
    logic [4:0]  rob_tail;
    logic        e_ready;
    logic [3:0]  e_pop, e_wr, e_alloc;
    logic [23:0] e_new, e_old, e_rs1, e_rs2;
    logic [19:0] e_rob;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  function automatic logic [19:0] a4(input int s0, input int s1, input int s2, input int s3);
    return {5'(s3), 5'(s2), 5'(s1), 5'(s0)};
  endfunction

  function automatic logic [23:0] p4(input int s0, input int s1, input int s2, input int s3);
    return {6'(s3), 6'(s2), 6'(s1), 6'(s0)};
  endfunction

  function automatic logic [255:0] pay(input int v);
    logic [255:0] p;
    for (int s = 0; s < 4; s++)
      p[s*64 +: 64] = 64'hA5A5_0000_0000_0000 | 64'(v * 16 + s);
    return p;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic drive(input int v);
    in_valid    = vecs[v].valid;
    in_wr_rd    = vecs[v].wr;
    in_rs1_arch = vecs[v].rs1;
    in_rs2_arch = vecs[v].rs2;
    in_rd_arch  = vecs[v].rd;
    fl_avail    = vecs[v].fl_avail;
    fl_phy      = vecs[v].fl_phy;
    rob_free    = vecs[v].rob_free;
    rob_tail    = vecs[v].rob_tail;
    in_payload  = pay(v);
  endtask

  task automatic fill(input int v, input logic [3:0] valid, input logic [3:0] wr,
                      input logic [19:0] rs1, input logic [19:0] rs2, input logic [19:0] rd,
                      input int fa, input logic [23:0] fp, input int rf, input int rt,
                      input logic er, input logic [3:0] ep, input logic [3:0] ew,
                      input logic [3:0] ea, input logic [23:0] en, input logic [23:0] eo,
                      input logic [23:0] e1, input logic [23:0] e2, input logic [19:0] eb);
    vecs[v] = '{valid, wr, rs1, rs2, rd, 7'(fa), fp, 6'(rf), 5'(rt),
                er, ep, ew, ea, en, eo, e1, e2, eb};
  endtask

  initial begin
    // independent group, ROB id wraps past 31
    fill(0, 4'b1111, 4'b1111, a4(6,7,8,9), a4(0,0,0,0), a4(1,2,3,4), 10, p4(40,41,42,43), 16, 30,
         1'b1, 4'b1111, 4'b1111, 4'b1111, p4(40,41,42,43), p4(5,6,7,8),
         p4(10,11,12,13), p4(0,0,0,0), a4(30,31,0,1));
    // RAW/WAW chain on x5, exact fit on free list and ROB
    fill(1, 4'b0111, 4'b0011, a4(1,5,0,0), a4(2,3,5,0), a4(5,5,7,0), 2, p4(20,21,22,23), 3, 5,
         1'b1, 4'b0011, 4'b0011, 4'b0111, p4(20,21,0,0), p4(9,20,11,4),
         p4(5,20,0,0), p4(6,7,21,0), a4(5,6,7,8));
    // x0 destination and store: slot3 takes fl_phy[1]
    fill(2, 4'b1111, 4'b1011, a4(10,3,0,9), a4(0,0,3,1), a4(3,0,9,10), 2, p4(50,51,52,53), 4, 0,
         1'b1, 4'b0011, 4'b1001, 4'b1111, p4(50,0,0,51), p4(7,4,13,14),
         p4(14,50,0,13), p4(0,0,50,5), a4(0,1,2,3));
    // free list one short
    fill(3, 4'b0111, 4'b0111, a4(0,0,0,0), a4(0,0,0,0), a4(1,2,3,0), 2, p4(30,31,32,33), 8, 2,
         1'b0, 4'b0000, 4'b0000, 4'b0000, p4(30,31,32,0), p4(5,6,7,4),
         p4(0,0,0,0), p4(0,0,0,0), a4(0,0,0,0));
    // free list exact
    fill(4, 4'b0111, 4'b0111, a4(0,0,0,0), a4(0,0,0,0), a4(1,2,3,0), 3, p4(30,31,32,33), 3, 2,
         1'b1, 4'b0111, 4'b0111, 4'b0111, p4(30,31,32,0), p4(5,6,7,4),
         p4(0,0,0,0), p4(0,0,0,0), a4(2,3,4,5));
    // ROB one short
    fill(5, 4'b1111, 4'b0000, a4(0,0,0,0), a4(0,0,0,0), a4(0,0,0,0), 0, p4(1,2,3,4), 3, 31,
         1'b0, 4'b0000, 4'b0000, 4'b0000, p4(0,0,0,0), p4(4,4,4,4),
         p4(0,0,0,0), p4(0,0,0,0), a4(0,0,0,0));
    // ROB exact, no destinations
    fill(6, 4'b1111, 4'b0000, a4(0,0,0,0), a4(0,0,0,0), a4(0,0,0,0), 0, p4(1,2,3,4), 4, 31,
         1'b1, 4'b0000, 4'b0000, 4'b1111, p4(0,0,0,0), p4(4,4,4,4),
         p4(0,0,0,0), p4(0,0,0,0), a4(31,0,1,2));

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_out_rd", out_rd_phy, 24'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_rat_wr_en", rat_wr_en, 4'b0000);
    chk("rst_fl_pop", fl_pop, 4'b0000);
    @(negedge clk); rst = 1'b0;

    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      drive(v);
      #1;
      chk($sformatf("v%0d_in_ready", v), in_ready, vecs[v].e_ready);
      chk($sformatf("v%0d_fl_pop", v), fl_pop, vecs[v].e_pop);
      chk($sformatf("v%0d_rat_wr_en", v), rat_wr_en, vecs[v].e_wr);
      chk($sformatf("v%0d_busy_set", v), busy_set, vecs[v].e_wr);
      chk($sformatf("v%0d_rob_alloc", v), rob_alloc, vecs[v].e_alloc);
      chk($sformatf("v%0d_new_phy", v), new_phy, vecs[v].e_new);
      chk($sformatf("v%0d_old_phy", v), old_phy, vecs[v].e_old);
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", v), out_valid, vecs[v].e_ready ? vecs[v].valid : 4'b0000);
      if (vecs[v].e_ready) begin
        chk($sformatf("v%0d_out_rd", v), out_rd_phy, vecs[v].e_new);
        chk($sformatf("v%0d_out_rs1", v), out_rs1_phy, vecs[v].e_rs1);
        chk($sformatf("v%0d_out_rs2", v), out_rs2_phy, vecs[v].e_rs2);
        chk($sformatf("v%0d_out_rob", v), out_rob_id, vecs[v].e_rob);
        chk($sformatf("v%0d_out_payload", v), out_payload, pay(v));
      end
    end

    // back-pressure: hold group 0 for three cycles, then refill with group 2
    @(negedge clk); drive(0); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_load_valid", out_valid, 4'b1111);
    @(negedge clk); drive(2); out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", c), in_ready, 1'b0);
      chk($sformatf("bp%0d_rat_wr_en", c), rat_wr_en, 4'b0000);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_out_valid", c), out_valid, 4'b1111);
      chk($sformatf("bp%0d_out_rd", c), out_rd_phy, vecs[0].e_new);
      chk($sformatf("bp%0d_out_rob", c), out_rob_id, vecs[0].e_rob);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("refill_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    chk("refill_out_valid", out_valid, 4'b1111);
    chk("refill_out_rd", out_rd_phy, vecs[2].e_new);
    chk("refill_out_rob", out_rob_id, vecs[2].e_rob);

    // flush with full output and an otherwise-firing group
    @(negedge clk); drive(0); out_ready = 1'b1; flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 1'b0);
    chk("flush_rat_wr_en", rat_wr_en, 4'b0000);
    chk("flush_fl_pop", fl_pop, 4'b0000);
    chk("flush_rob_alloc", rob_alloc, 4'b0000);
    @(posedge clk); #1;
    chk("flush_out_valid", out_valid, 4'b0000);
    @(negedge clk); flush = 1'b0;

    // synchronous reset mid-stream
    drive(1);
    @(posedge clk); #1;
    chk("pre_rst_out_valid", out_valid, 4'b0111);
    @(negedge clk); drive(0); rst = 1'b1;
    #1;
    chk("mid_rst_rat_wr_en", rat_wr_en, 4'b0000);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    chk("mid_rst_out_valid", out_valid, 4'b0000);
    chk("mid_rst_out_rd", out_rd_phy, 24'd0);
    chk("mid_rst_out_rs1", out_rs1_phy, 24'd0);
    chk("mid_rst_out_rob", out_rob_id, 20'd0);
    chk("mid_rst_out_payload", out_payload, 256'd0);
    @(negedge clk); rst = 1'b0; in_valid = 4'b0000;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rename_group_n.md
Name: rename_group_n

Overview:
- Parametrised N-wide register-rename stage between decode and dispatch/reservation stations.
- Takes a group of up to WIDTH decoded instructions and reads source and old-destination mappings from the front RAT.
- Allocates new physical destinations from the free list, resolves intra-group RAW/WAW dependencies, reserves ROB entries, and registers the renamed group into a one-entry output stage with valid/ready handshakes on both sides.
- Adds all-or-nothing group acceptance, resource-based stall, and flush.

Parameters:
- WIDTH, 4, instructions per group (1..8).
- ARCH_REGS, 32, architectural registers; index width AW = $clog2(ARCH_REGS).
- PHY_REGS, 64, physical registers.
- PHY_WIDTH, 6, physical register index width.
- ROB_WIDTH, 5, ROB index width.
- PAYLOAD_W, 64, opaque per-slot payload (pc, opcode, funct, imm) passed through.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush (mispredict/exception)
- in_valid  in  WIDTH  per-slot valid; must be contiguous from slot 0
- in_ready  out  1  group accepted this cycle when in_valid!=0 && in_ready
- in_rs1_arch, in_rs2_arch, in_rd_arch  in  WIDTH*AW  architectural indices per slot
- in_wr_rd  in  WIDTH  slot writes rd (decoder clears for store/branch)
- in_payload  in  WIDTH*PAYLOAD_W  pass-through
- rat_rs1_phy, rat_rs2_phy, rat_rd_phy  in  WIDTH*PHY_WIDTH  combinational RAT lookups of in_*_arch
- rat_wr_en  out  WIDTH  RAT update enables (slot i: fire && wdest[i])
- fl_avail  in  $clog2(PHY_REGS)+1  free registers available
- fl_phy  in  WIDTH*PHY_WIDTH  next WIDTH free registers, in order
- fl_pop  out  WIDTH  pop mask, compacted: popcount = number of dests
- rob_free  in  ROB_WIDTH+1  free ROB entries
- rob_tail  in  ROB_WIDTH  index of next ROB entry
- rob_alloc  out  WIDTH  ROB allocate mask (= in_valid on fire)
- busy_set  out  WIDTH  mark new phy busy (= rat_wr_en)
- new_phy  out  WIDTH*PHY_WIDTH  allocated phy per slot; 0 when no dest
- old_phy  out  WIDTH*PHY_WIDTH  previous mapping per slot, for the ROB
- out_valid  out  WIDTH  registered renamed group valid
- out_ready  in  1  downstream accepts group
- out_rs1_phy, out_rs2_phy, out_rd_phy  out  WIDTH*PHY_WIDTH  renamed indices
- out_rob_id  out  WIDTH*ROB_WIDTH  rob_tail+i, modulo 2^ROB_WIDTH
- out_payload  out  WIDTH*PAYLOAD_W

Behaviour:
- Destination qualifier: wdest[i] = in_valid[i] && in_wr_rd[i] && in_rd_arch[i]!=0. x0 never allocates; rd_phy for x0 = 0.
- Allocation: slot i takes fl_phy[k], where k = count of wdest[j] for j<i (prefix popcount).
- Source bypass: rs1/rs2 of slot i use new_phy of the youngest j<i with wdest[j] and rd_arch[j]==rs_arch[i]; otherwise the RAT value. Source x0 always maps to phy 0.
- old_phy bypass: old_phy[i] uses the same rule on in_rd_arch[i] (WAW), so the ROB frees the correct register.
- Accept condition: in_ready = !flush && fl_avail >= popcount(wdest) && rob_free >= popcount(in_valid) && (out_valid==0 || out_ready).
  - fire = in_ready && |in_valid.
  - All side-effect outputs (rat_wr_en, fl_pop, rob_alloc, busy_set) are zero unless fire.
  - No partial groups.
- Latency: 1 cycle from fire to out_valid.
- Output register holds its contents while out_valid!=0 && !out_ready.
- Drain without refill: output cleared to out_valid=0.
- Drain with refill in the same cycle: back-to-back, full throughput.
- ROB id wrap: rob_tail+i wraps modulo 2^ROB_WIDTH.
- Boundary: exact fit (fl_avail == needed, or rob_free == count) accepts. One short stalls the whole group.
- Flush: out_valid <= 0 next cycle; in_ready=0 in the flush cycle; no allocation that cycle. Flush overrides a simultaneous fire.
- Reset (sync): out_valid=0; all out_* data=0. Combinational side-effect outputs are 0 while rst=1.
- Non-contiguous in_valid is illegal (assertion only).

Optional Feature:
- Macro RENAME_GROUP_STATS_EN.
- When defined: adds 32-bit saturating counters plus output ports stat_fl_stall, stat_rob_stall, stat_bp_stall (back-pressure) and stat_groups, all reset to 0.
  - A stall cycle (|in_valid && !in_ready && !flush) increments the first matching cause, priority FL > ROB > back-pressure.
  - stat_groups counts fires.
- When undefined: no counters and no stat ports.

Test Plan:
- WIDTH=4, independent group: rd=1,2,3,4, fl_phy=40..43, rob_tail=30 -> out_rd_phy=40,41,42,43; out_rob_id=30,31,0,1; fl_pop=4'b1111.
- Intra-group RAW/WAW: slot0 rd=5, slot1 rs1=5 rd=5, slot2 rs2=5; RAT[5]=9; fl_phy=20,21 -> slot1 rs1=20, old_phy[1]=20, slot2 rs2=21; old_phy[0]=9.
- x0 and store mix: slot1 rd=0, slot2 in_wr_rd=0 -> fl_pop=4'b0011; new_phy[1]=new_phy[2]=0; slot3 receives fl_phy[1].
- Resource stall: fl_avail=2 with 3 dests -> in_ready=0 and no pops. fl_avail=3 -> fires. Repeat with rob_free=3 for 4 valid slots -> stall.
- Back-pressure: out_ready=0 for 3 cycles with a held group -> output stable, in_ready=0. out_ready=1 while new group is pending -> new group appears the next cycle with no bubble.
- Flush and reset: flush asserted with a pending fire and a full output -> no rat_wr_en, out_valid=0 next cycle. Sync rst mid-stream -> all outputs 0 on the following edge.
